// File: rtl/clint_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp) with a prescaled 64-bit counter.
// Optional machine software interrupt register (MSIP) enabled by CLINT_MSIP_EN.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        rd_valid,
    output logic        timer_interrupt
`ifdef CLINT_MSIP_EN
    ,
    output logic        sw_interrupt
`endif
);

    localparam logic [15:0] PS_MAX      = 16'(PRESCALE - 1);
    localparam logic [15:0] OFF_MSIP    = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
    localparam logic [15:0] OFF_CTRL    = 16'h8000;
    localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        run;
    logic [15:0] pcnt;
    logic [15:0] off;
    logic        sel;
    logic        rd_hit;
    logic        wr_hit;
    logic        mtime_wr;
    logic [31:0] rd_word;
    logic        unused_addr;
`ifdef CLINT_MSIP_EN
    logic        msip;
`endif

    // Byte offset within the window, word aligned; the low address bits are don't-care.
    assign off         = {addr[15:2], 2'b00};
    assign unused_addr = ^addr[1:0];
    assign sel         = (addr[31:16] == BASE_ADDR[31:16]);
    assign rd_hit      = rd_en && sel;
    assign wr_hit      = wr_en && sel;
    assign mtime_wr    = wr_hit && ((off == OFF_TIME_LO) || (off == OFF_TIME_HI));

    always_comb begin
        rd_word = '0;
        case (off)
            OFF_CMP_LO:  rd_word = mtimecmp[31:0];
            OFF_CMP_HI:  rd_word = mtimecmp[63:32];
            OFF_CTRL:    rd_word = {31'b0, run};
            OFF_TIME_LO: rd_word = mtime[31:0];
            OFF_TIME_HI: rd_word = mtime[63:32];
`ifdef CLINT_MSIP_EN
            OFF_MSIP:    rd_word = {31'b0, msip};
`endif
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime           <= '0;
            mtimecmp        <= '1;
            run             <= 1'b1;
            pcnt            <= '0;
            rdata           <= '0;
            rd_valid        <= 1'b0;
            timer_interrupt <= 1'b0;
`ifdef CLINT_MSIP_EN
            msip            <= 1'b0;
            sw_interrupt    <= 1'b0;
`endif
        end else begin
            // rd_word reflects pre-write state, so a same-cycle read sees the old value.
            rd_valid <= rd_hit;
            if (rd_hit) begin
                rdata <= rd_word;
            end

            if (wr_hit && off == OFF_CMP_LO) begin
                mtimecmp[31:0] <= wdata;
            end
            if (wr_hit && off == OFF_CMP_HI) begin
                mtimecmp[63:32] <= wdata;
            end
            if (wr_hit && off == OFF_CTRL) begin
                run <= wdata[0];
            end

            // A software write to mtime wins over the tick and restarts the prescaler.
            if (mtime_wr) begin
                pcnt <= '0;
                if (off == OFF_TIME_LO) begin
                    mtime[31:0] <= wdata;
                end else begin
                    mtime[63:32] <= wdata;
                end
            end else if (run) begin
                if (pcnt == PS_MAX) begin
                    pcnt  <= '0;
                    mtime <= mtime + 64'd1;
                end else begin
                    pcnt <= pcnt + 16'd1;
                end
            end

            timer_interrupt <= (mtime >= mtimecmp);

`ifdef CLINT_MSIP_EN
            if (wr_hit && off == OFF_MSIP) begin
                msip <= wdata[0];
            end
            sw_interrupt <= msip;
`endif
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer (PRESCALE=4); reads push expected data into a
// queue that a negedge monitor drains whenever rd_valid is seen.
module tb_clint_timer;

    localparam logic [31:0] BASE    = 32'h0200_0000;
    localparam logic [31:0] MSIP    = BASE | 32'h0000;
    localparam logic [31:0] CMP_LO  = BASE | 32'h4000;
    localparam logic [31:0] CMP_HI  = BASE | 32'h4004;
    localparam logic [31:0] CTRL    = BASE | 32'h8000;
    localparam logic [31:0] TIME_LO = BASE | 32'hBFF8;
    localparam logic [31:0] TIME_HI = BASE | 32'hBFFC;
    localparam logic [31:0] UNMAP   = BASE | 32'h0100;
    localparam logic [31:0] OUTSIDE = 32'h0300_4000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        timer_interrupt;
`ifdef CLINT_MSIP_EN
    logic        sw_interrupt;
`endif

    logic [31:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    clint_timer #(
        .BASE_ADDR(BASE),
        .PRESCALE (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .wdata          (wdata),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .rdata          (rdata),
        .rd_valid       (rd_valid),
        .timer_interrupt(timer_interrupt)
`ifdef CLINT_MSIP_EN
        ,
        .sw_interrupt   (sw_interrupt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%h exp=%h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: act rdata=%h exp=no read", rdata);
            end else begin
                check("read_data", rdata, exp_q.pop_front());
            end
        end
    end

    // driver tasks: entered 1 time unit after a posedge, return 1 time unit after the next
    task automatic idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        addr  = a;
        rd_en = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        rd_en = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_read_none(input logic [31:0] a);
        addr  = a;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check("outside_no_rd_valid", {31'b0, rd_valid}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        addr  = '0;
        wdata = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_irq", {31'b0, timer_interrupt}, 32'd0);

        // reset values
        do_read(TIME_LO, 32'd0);
        do_read(CMP_HI, 32'hFFFF_FFFF);
        do_read(CMP_LO, 32'hFFFF_FFFF);
        do_read(CTRL, 32'd1);
        check("reset_irq_after_reads", {31'b0, timer_interrupt}, 32'd0);

        // count rate: 40 cycles at prescale 4 -> 10
        do_write(TIME_LO, 32'd0);
        idle(40);
        do_read(TIME_LO, 32'd10);

        // carry from LO into HI
        do_write(TIME_LO, 32'hFFFF_FFFF);
        do_write(TIME_HI, 32'd0);
        idle(4);
        do_read(TIME_LO, 32'd0);
        do_read(TIME_HI, 32'd1);

        // interrupt assertion and clear
        do_write(CTRL, 32'd0);
        do_write(TIME_HI, 32'd0);
        do_write(TIME_LO, 32'd0);
        do_write(CMP_HI, 32'd0);
        do_write(CMP_LO, 32'd5);
        check("irq_before_run", {31'b0, timer_interrupt}, 32'd0);
        do_write(CTRL, 32'd1);
        idle(20);
        check("irq_at_mtime5", {31'b0, timer_interrupt}, 32'd0);
        idle(1);
        check("irq_rise", {31'b0, timer_interrupt}, 32'd1);
        do_write(CMP_LO, 32'd100);
        check("irq_hold_on_cmp_write", {31'b0, timer_interrupt}, 32'd1);
        idle(1);
        check("irq_fall", {31'b0, timer_interrupt}, 32'd0);

        // run control
        do_write(CTRL, 32'd0);
        do_read(TIME_LO, 32'd6);
        idle(20);
        do_read(TIME_LO, 32'd6);

        // mtime write beats the prescale wrap
        do_write(CTRL, 32'd1);
        idle(3);
        do_write(TIME_LO, 32'd7);
        do_read(TIME_LO, 32'd7);
        do_read(TIME_HI, 32'd0);
        do_read(CTRL, 32'd1);

        // same-cycle read and write
        do_write(CMP_HI, 32'hFFFF_FFFF);
        do_write(CMP_LO, 32'hFFFF_FFFF);
        do_rw(CMP_LO, 32'h0000_1234, 32'hFFFF_FFFF);
        do_read(CMP_LO, 32'h0000_1234);
        idle(3);
        check("rdata_hold", rdata, 32'h0000_1234);
        check("rd_valid_idle", {31'b0, rd_valid}, 32'd0);

        // unmapped and out-of-window accesses
        do_write(UNMAP, 32'hDEAD_BEEF);
        do_read(UNMAP, 32'd0);
        do_read(MSIP, 32'd0);
        do_write(OUTSIDE, 32'd0);
        do_read_none(OUTSIDE);
        do_read(CMP_LO, 32'h0000_1234);

        // CTRL keeps only bit0
        do_write(CTRL, 32'hFFFF_FFFE);
        do_read(CTRL, 32'd0);
        do_write(CTRL, 32'd3);
        do_read(CTRL, 32'd1);

`ifdef CLINT_MSIP_EN
        do_write(MSIP, 32'd1);
        check("sw_irq_latency", {31'b0, sw_interrupt}, 32'd0);
        idle(1);
        check("sw_irq_set", {31'b0, sw_interrupt}, 32'd1);
        do_read(MSIP, 32'd1);
        do_write(MSIP, 32'd0);
        idle(1);
        check("sw_irq_clear", {31'b0, sw_interrupt}, 32'd0);
`else
        do_write(MSIP, 32'd1);
        do_read(MSIP, 32'd0);
`endif

        // reset while a read is in flight
        idle(2);
        addr  = TIME_LO;
        rd_en = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rd_en = 1'b0;
        check("midreset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_irq", {31'b0, timer_interrupt}, 32'd0);
        do_read(CMP_HI, 32'hFFFF_FFFF);
        do_read(TIME_LO, 32'd0);
        do_read(CTRL, 32'd1);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped machine timer (mtime/mtimecmp, RISC-V CLINT subset).
- Produces the `timer_interrupt` level consumed by the processor core's CSR/trap logic.
- Sits on the data-memory bus next to `data_mem`; the core accesses it with word loads/stores, which the address decode steers to it.

Parameters:
- BASE_ADDR, 32'h0200_0000, byte base address of the register window (64 KiB window).
- PRESCALE, 4, number of clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- addr  input  32  byte address from the core; bits [1:0] ignored
- wdata  input  32  write data
- wr_en  input  1  write strobe, one word per cycle
- rd_en  input  1  read strobe
- rdata  output  32  registered read data
- rd_valid  output  1  high exactly one cycle after an accepted read
- timer_interrupt  output  1  level interrupt to the core
- sw_interrupt  output  1  only with CLINT_MSIP_EN (see below)

Behaviour:
- Access acceptance: an access is accepted when `rd_en` or `wr_en` is high and `addr[31:16] == BASE_ADDR[31:16]`.
- Register map (offset = `addr[15:0]`):
  - 0x4000 MTIMECMP_LO, RW
  - 0x4004 MTIMECMP_HI, RW
  - 0x8000 CTRL, RW; bit0 = run, other bits read 0
  - 0xBFF8 MTIME_LO, RW
  - 0xBFFC MTIME_HI, RW
  - 0x0000 MSIP, optional
  - Other offsets in the window: reads return 0, writes ignored.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, run = 1, prescale count = 0.
  - Outputs: rdata = 0, rd_valid = 0, timer_interrupt = 0, sw_interrupt = 0.
- Prescaler:
  - Counter runs 0..PRESCALE-1 while run = 1.
  - When it wraps, mtime increments by 1 (64-bit, carry from LO into HI); 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - With run = 0, the counter and mtime hold.
  - PRESCALE = 1 means mtime increments every cycle.
- Writes:
  - Take effect at the clock edge; the new value is visible to a read on the next cycle.
  - A write to MTIME_LO or MTIME_HI replaces that half only.
  - Any mtime write suppresses that cycle's increment (no carry into the unwritten half) and clears the prescale counter to 0.
- Reads:
  - rdata and rd_valid are updated one cycle after the request (1-cycle latency).
  - rdata holds its value until the next accepted read.
  - rd_valid is otherwise 0.
- Simultaneous rd_en and wr_en to the same offset: the write is performed; the read returns the pre-write value.
- Interrupt:
  - timer_interrupt is registered: it equals (mtime >= mtimecmp) evaluated on the mtime/mtimecmp values that are current at the edge (unsigned 64-bit compare).
  - It therefore asserts one cycle after the condition becomes true.
  - It stays high until software raises mtimecmp or lowers mtime; no clear-on-read.
- Non-atomic 64-bit updates are software's responsibility. The expected sequence is: write MTIMECMP_HI = FFFF_FFFF, then LO, then HI. The hardware adds no shadowing.
- Reset mid-operation: all state returns to reset values on the next edge. A read in flight is dropped (rd_valid = 0).

Optional Feature:
- Macro `CLINT_MSIP_EN`.
- Defined:
  - Adds MSIP at offset 0x0000; bit0 is RW, other bits read 0, reset 0.
  - `sw_interrupt` is a registered copy of MSIP bit0 and asserts one cycle after the write.
- Undefined:
  - The `sw_interrupt` port is absent.
  - Offset 0x0000 behaves as unmapped (reads 0, writes ignored).

Test Plan:
- Reset values: PRESCALE=4. Assert rst 2 cycles, release, read MTIME_LO immediately → rd_valid next cycle, rdata=0. Read MTIMECMP_HI → 32'hFFFF_FFFF. timer_interrupt = 0 throughout.
- Count rate and carry: PRESCALE=4, run. After 40 cycles MTIME_LO = 10 (±1 for the read path). Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0, wait 4 cycles → MTIME_LO=0, MTIME_HI=1.
- Interrupt assertion and clear: mtime=0, write MTIMECMP_HI=0, MTIMECMP_LO=5, PRESCALE=1 → timer_interrupt rises exactly one cycle after mtime reaches 5. Write MTIMECMP_LO=100 → timer_interrupt falls one cycle later.
- Run control and write priority: write CTRL=0 → mtime frozen for 20 cycles. Write MTIME_LO=7 while run=1 on a prescale wrap cycle → next read = 7, not 8.
- Same-cycle read and write; unmapped accesses: rd_en and wr_en to MTIMECMP_LO with wdata=0x1234, old value 0xFFFF_FFFF → rdata=0xFFFF_FFFF, next read 0x1234. Read offset 0x0100 → 0. Access with `addr[31:16]` != base → no rd_valid.
- With CLINT_MSIP_EN: write MSIP=1 → sw_interrupt=1 next cycle; write 0 → sw_interrupt=0. Without the macro, offset 0x0000 reads 0.
